// File: rtl/alarm_pkg.sv
// Shared state encoding and default timing for the alarm sequencer.
package alarm_pkg;

   typedef enum logic [2:0] {
      DISARMED    = 3'd0,
      EXIT_DELAY  = 3'd1,
      ARMED       = 3'd2,
      ENTRY_DELAY = 3'd3,
      ALARM       = 3'd4
   } state_t;

   localparam int DEF_TICK_DIV    = 25_000_000;
   localparam int DEF_EXIT_TICKS  = 60;
   localparam int DEF_ENTRY_TICKS = 30;
   localparam int DEF_ALARM_TICKS = 360;

   function automatic logic is_armed(input state_t s);
      return (s == ARMED) || (s == ENTRY_DELAY) || (s == ALARM);
   endfunction

   function automatic logic is_delay(input state_t s);
      return (s == EXIT_DELAY) || (s == ENTRY_DELAY);
   endfunction

endpackage

// File: rtl/alarm_tick_gen.sv
// Tick prescaler: one-cycle tick every TICK_DIV clocks, restartable.
module alarm_tick_gen
   import alarm_pkg::*;
#(
   parameter int TICK_DIV = DEF_TICK_DIV
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q;

   assign tick = (cnt_q == LAST);

   always_ff @(posedge clk) begin
      if (rst || clr || tick)
         cnt_q <= '0;
      else
         cnt_q <= cnt_q + 1'b1;
   end

endmodule

// File: rtl/alarm_sequencer.sv
// Arm/disarm sequencer with exit/entry delays and a timed siren.
module alarm_sequencer
   import alarm_pkg::*;
#(
   parameter int                NZONES       = 4,
   parameter logic [NZONES-1:0] INSTANT_MASK = NZONES'(1),
   parameter int                TICK_DIV     = DEF_TICK_DIV,
   parameter int                EXIT_TICKS   = DEF_EXIT_TICKS,
   parameter int                ENTRY_TICKS  = DEF_ENTRY_TICKS,
   parameter int                ALARM_TICKS  = DEF_ALARM_TICKS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              arm,
   input  logic              disarm,
   input  logic [NZONES-1:0] zone,
   output logic              buzzer_aux,
   output logic [2:0]        state,
   output logic [NZONES-1:0] tripped,
   output logic              arm_fault,
   output logic              armed_led
);

   localparam int MAX_EE = (EXIT_TICKS > ENTRY_TICKS) ? EXIT_TICKS : ENTRY_TICKS;
   localparam int MAXT   = (MAX_EE > ALARM_TICKS) ? MAX_EE : ALARM_TICKS;
   localparam int TW     = $clog2(MAXT + 1);

   localparam logic [TW-1:0] EXIT_LAST  = TW'(EXIT_TICKS - 1);
   localparam logic [TW-1:0] ENTRY_LAST = TW'(ENTRY_TICKS - 1);
   localparam logic [TW-1:0] ALARM_LAST = TW'(ALARM_TICKS - 1);
   localparam logic [TW-1:0] TSAT       = TW'(MAXT);

   state_t            st_q, st_n;
   logic [TW-1:0]     tcnt_q;
   logic              beep_q, beep_n;
   logic [NZONES-1:0] bypass_q, bypass_n;
   logic [NZONES-1:0] trip_n, active;
   logic              tick, clr;
   logic              fault_n, aux_n, led_n;
   logic              instant;

   alarm_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .tick (tick)
   );

   assign clr     = (st_n != st_q);
   assign active  = zone & ~bypass_q;
   assign instant = |(active & INSTANT_MASK);
   assign state   = st_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q       <= DISARMED;
         tcnt_q     <= '0;
         beep_q     <= 1'b0;
         bypass_q   <= '0;
         tripped    <= '0;
         arm_fault  <= 1'b0;
         buzzer_aux <= 1'b0;
         armed_led  <= 1'b0;
      end else begin
         st_q       <= st_n;
         beep_q     <= beep_n;
         bypass_q   <= bypass_n;
         tripped    <= trip_n;
         arm_fault  <= fault_n;
         buzzer_aux <= aux_n;
         armed_led  <= led_n;
         if (clr)
            tcnt_q <= '0;
         else if (tick && tcnt_q != TSAT)
            tcnt_q <= tcnt_q + 1'b1;
      end
   end

   // disarm outranks every other event in every state
   always_comb begin
      st_n     = st_q;
      bypass_n = bypass_q;
      trip_n   = tripped;
      fault_n  = 1'b0;
      unique case (st_q)
         DISARMED: begin
            if (arm && !disarm) begin
               if (|zone) begin
                  fault_n = 1'b1;
               end else begin
                  st_n   = EXIT_DELAY;
                  trip_n = '0;
               end
            end
         end
         EXIT_DELAY: begin
            if (disarm) begin
               st_n = DISARMED;
            end else if (tick && tcnt_q == EXIT_LAST) begin
               st_n     = ARMED;
               bypass_n = zone;
            end
         end
         ARMED: begin
            bypass_n = bypass_q & zone;
            if (disarm) begin
               st_n = DISARMED;
            end else if (instant) begin
               st_n   = ALARM;
               trip_n = active;
            end else if (|active) begin
               st_n   = ENTRY_DELAY;
               trip_n = active;
            end
         end
         ENTRY_DELAY: begin
            if (disarm) begin
               st_n = DISARMED;
            end else if (instant) begin
               st_n   = ALARM;
               trip_n = tripped | active;
            end else if (tick && tcnt_q == ENTRY_LAST) begin
               st_n = ALARM;
            end
         end
         ALARM: begin
            if (disarm) begin
               st_n = DISARMED;
            end else if (tick && tcnt_q == ALARM_LAST) begin
               st_n     = ARMED;
               bypass_n = zone;
            end
         end
         default: st_n = DISARMED;
      endcase
   end

   always_comb begin
      beep_n = beep_q ^ tick;
      if (clr && is_delay(st_n))
         beep_n = 1'b1;
      aux_n = 1'b0;
      if (is_delay(st_n))
         aux_n = beep_n;
      else if (st_n == ALARM)
         aux_n = 1'b1;
      led_n = is_armed(st_n);
   end

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed scenarios plus randomized run against a cycle-count model.
module tb_alarm_sequencer;

   localparam int TD = 4;
   localparam int EX = 3;
   localparam int EN = 2;
   localparam int AL = 5;

   logic       clk = 1'b0;
   logic       rst, arm, disarm;
   logic [3:0] zone;
   logic       buzzer_aux, arm_fault, armed_led;
   logic [2:0] state;
   logic [3:0] tripped;

   int tests = 0;
   int fails = 0;

   int         ms = 0;
   int         mc = 0;
   logic [3:0] mbyp = '0;
   logic [3:0] mtrip = '0;
   logic       mfault = 1'b0;

   alarm_sequencer #(
      .NZONES       (4),
      .INSTANT_MASK (4'b0001),
      .TICK_DIV     (TD),
      .EXIT_TICKS   (EX),
      .ENTRY_TICKS  (EN),
      .ALARM_TICKS  (AL)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .arm        (arm),
      .disarm     (disarm),
      .zone       (zone),
      .buzzer_aux (buzzer_aux),
      .state      (state),
      .tripped    (tripped),
      .arm_fault  (arm_fault),
      .armed_led  (armed_led)
   );

   always #5 clk = ~clk;

   // states: 0 off, 1 exit, 2 armed, 3 entry, 4 siren; mc = cycles in state
   task automatic model_step();
      int         ns;
      logic [3:0] act;
      if (rst) begin
         ms = 0; mc = 0; mbyp = '0; mtrip = '0; mfault = 1'b0;
         return;
      end
      mfault = 1'b0;
      ns = ms;
      act = zone & ~mbyp;
      case (ms)
         0: if (arm && !disarm) begin
               if (zone != 0) mfault = 1'b1;
               else begin ns = 1; mtrip = '0; end
            end
         1: if (disarm) ns = 0;
            else if (mc == EX * TD - 1) begin ns = 2; mbyp = zone; end
         2: begin
               if (disarm) ns = 0;
               else if (act[0]) begin ns = 4; mtrip = act; end
               else if (act != 0) begin ns = 3; mtrip = act; end
               mbyp = mbyp & zone;
            end
         3: if (disarm) ns = 0;
            else if (act[0]) begin ns = 4; mtrip = mtrip | act; end
            else if (mc == EN * TD - 1) ns = 4;
         4: if (disarm) ns = 0;
            else if (mc == AL * TD - 1) begin ns = 2; mbyp = zone; end
         default: ns = 0;
      endcase
      mc = (ns != ms) ? 0 : mc + 1;
      ms = ns;
   endtask

   function automatic logic exp_aux();
      if (ms == 1 || ms == 3) return ((mc / TD) % 2) == 0;
      return ms == 4;
   endfunction

   task automatic cyc(input logic a, input logic d, input logic [3:0] z,
                      input logic r = 1'b0);
      arm = a; disarm = d; zone = z; rst = r;
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic go_armed();
      cyc(1'b1, 1'b0, 4'b0000);
      repeat (EX * TD) cyc(1'b0, 1'b0, 4'b0000);
   endtask

   task automatic test_reset();
      cyc(1'b0, 1'b0, 4'b0000, 1'b1);
      tests++;
      if (state !== 3'd0) begin
         fails++; $display("FAIL reset_state: got %0d want 0", state);
      end
      tests++;
      if ({buzzer_aux, tripped, arm_fault, armed_led} !== 7'd0) begin
         fails++;
         $display("FAIL reset_outs: got aux=%b trip=%b flt=%b led=%b want 0",
                  buzzer_aux, tripped, arm_fault, armed_led);
      end
      cyc(1'b0, 1'b0, 4'b0000);
   endtask

   task automatic test_exit_delay();
      cyc(1'b1, 1'b0, 4'b0000);
      tests++;
      if ({state, buzzer_aux} !== {3'd1, 1'b1}) begin
         fails++; $display("FAIL exit_entry: got st=%0d aux=%b want 1/1", state, buzzer_aux);
      end
      for (int i = 1; i < EX * TD; i++) begin
         cyc(1'b0, 1'b0, 4'b0000);
         tests++;
         if ({state, buzzer_aux} !== {3'd1, 1'(((i / TD) % 2) == 0)}) begin
            fails++;
            $display("FAIL exit_beep[%0d]: got st=%0d aux=%b want st=1 aux=%b",
                     i, state, buzzer_aux, ((i / TD) % 2) == 0);
         end
      end
      cyc(1'b0, 1'b0, 4'b0000);
      tests++;
      if ({state, armed_led, buzzer_aux} !== {3'd2, 1'b1, 1'b0}) begin
         fails++;
         $display("FAIL exit_done: got st=%0d led=%b aux=%b want 2/1/0",
                  state, armed_led, buzzer_aux);
      end
   endtask

   task automatic test_entry_delay();
      cyc(1'b0, 1'b0, 4'b0100);
      tests++;
      if ({state, tripped, buzzer_aux} !== {3'd3, 4'b0100, 1'b1}) begin
         fails++;
         $display("FAIL entry_start: got st=%0d trip=%b aux=%b want 3/0100/1",
                  state, tripped, buzzer_aux);
      end
      for (int i = 1; i < EN * TD; i++) begin
         cyc(1'b0, 1'b0, 4'b0100);
         tests++;
         if (state !== 3'd3) begin
            fails++; $display("FAIL entry_hold[%0d]: got %0d want 3", i, state);
         end
      end
      cyc(1'b0, 1'b0, 4'b0100);
      tests++;
      if ({state, buzzer_aux} !== {3'd4, 1'b1}) begin
         fails++; $display("FAIL entry_timeout: got st=%0d aux=%b want 4/1", state, buzzer_aux);
      end
      cyc(1'b0, 1'b1, 4'b0000);
      tests++;
      if ({state, buzzer_aux, armed_led, tripped} !== {3'd0, 1'b0, 1'b0, 4'b0100}) begin
         fails++;
         $display("FAIL entry_disarm: got st=%0d aux=%b led=%b trip=%b want 0/0/0/0100",
                  state, buzzer_aux, armed_led, tripped);
      end
   endtask

   task automatic test_instant();
      cyc(1'b1, 1'b0, 4'b0000);
      tests++;
      if (tripped !== 4'b0000) begin
         fails++; $display("FAIL trip_clear_on_arm: got %b want 0000", tripped);
      end
      repeat (EX * TD) cyc(1'b0, 1'b0, 4'b0000);
      cyc(1'b0, 1'b0, 4'b0001);
      tests++;
      if ({state, tripped, armed_led, buzzer_aux} !== {3'd4, 4'b0001, 1'b1, 1'b1}) begin
         fails++;
         $display("FAIL instant: got st=%0d trip=%b led=%b aux=%b want 4/0001/1/1",
                  state, tripped, armed_led, buzzer_aux);
      end
   endtask

   task automatic test_alarm_rearm();
      for (int i = 1; i < AL * TD; i++) cyc(1'b0, 1'b0, 4'b0010);
      tests++;
      if (state !== 3'd4) begin
         fails++; $display("FAIL alarm_hold: got %0d want 4", state);
      end
      cyc(1'b0, 1'b0, 4'b0010);
      tests++;
      if ({state, buzzer_aux} !== {3'd2, 1'b0}) begin
         fails++; $display("FAIL alarm_timeout: got st=%0d aux=%b want 2/0", state, buzzer_aux);
      end
      repeat (5) cyc(1'b0, 1'b0, 4'b0010);
      tests++;
      if (state !== 3'd2) begin
         fails++; $display("FAIL bypass_hold: got %0d want 2", state);
      end
      cyc(1'b0, 1'b0, 4'b0000);
      cyc(1'b0, 1'b0, 4'b0010);
      tests++;
      if ({state, tripped} !== {3'd3, 4'b0010}) begin
         fails++; $display("FAIL bypass_release: got st=%0d trip=%b want 3/0010", state, tripped);
      end
      cyc(1'b0, 1'b1, 4'b0000);
   endtask

   task automatic test_arm_fault();
      cyc(1'b1, 1'b0, 4'b1000);
      tests++;
      if ({state, arm_fault} !== {3'd0, 1'b1}) begin
         fails++; $display("FAIL arm_fault: got st=%0d flt=%b want 0/1", state, arm_fault);
      end
      cyc(1'b0, 1'b0, 4'b1000);
      tests++;
      if ({state, arm_fault} !== {3'd0, 1'b0}) begin
         fails++; $display("FAIL arm_fault_pulse: got st=%0d flt=%b want 0/0", state, arm_fault);
      end
   endtask

   task automatic test_disarm_priority();
      cyc(1'b1, 1'b1, 4'b0000);
      tests++;
      if ({state, arm_fault} !== {3'd0, 1'b0}) begin
         fails++; $display("FAIL arm_disarm: got st=%0d flt=%b want 0/0", state, arm_fault);
      end
      go_armed();
      cyc(1'b0, 1'b0, 4'b0100);
      cyc(1'b0, 1'b1, 4'b0101);
      tests++;
      if ({state, buzzer_aux} !== {3'd0, 1'b0}) begin
         fails++; $display("FAIL disarm_vs_trip: got st=%0d aux=%b want 0/0", state, buzzer_aux);
      end
   endtask

   task automatic test_reset_mid_alarm();
      go_armed();
      cyc(1'b0, 1'b0, 4'b0001);
      cyc(1'b0, 1'b0, 4'b0001, 1'b1);
      tests++;
      if ({state, buzzer_aux, tripped, arm_fault, armed_led} !== 10'd0) begin
         fails++;
         $display("FAIL reset_alarm: got st=%0d aux=%b trip=%b flt=%b led=%b want 0",
                  state, buzzer_aux, tripped, arm_fault, armed_led);
      end
      cyc(1'b0, 1'b0, 4'b0000);
   endtask

   task automatic test_random();
      logic [3:0] z = '0;
      logic       a, d, r;
      logic [9:0] want;
      for (int i = 0; i < 4000; i++) begin
         a = ($urandom_range(0, 7) == 0);
         d = ($urandom_range(0, 59) == 0);
         r = ($urandom_range(0, 799) == 0);
         if ($urandom_range(0, 11) == 0)
            z = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
         cyc(a, d, z, r);
         want = {3'(ms), exp_aux(), mtrip, mfault, 1'(ms >= 2)};
         tests++;
         if ({state, buzzer_aux, tripped, arm_fault, armed_led} !== want) begin
            fails++;
            $display("FAIL random[%0d]: got st=%0d aux=%b trip=%b flt=%b led=%b want %b",
                     i, state, buzzer_aux, tripped, arm_fault, armed_led, want);
         end
      end
   endtask

   initial begin
      arm = 1'b0; disarm = 1'b0; zone = '0; rst = 1'b1;
      test_reset();
      test_exit_delay();
      test_entry_delay();
      test_instant();
      test_alarm_rearm();
      test_arm_fault();
      test_disarm_priority();
      test_reset_mid_alarm();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/alarm_sequencer.md
Name: alarm_sequencer

Overview:
- Controls the buzzer alarm: arm/disarm sequencing, exit and entry delays, and the alarm siren with a timeout, driven by N sensor zones.
- Drives the buzzer's `aux` control line through `buzzer_aux`:
  - 0 = speaker held steady (silent).
  - 1 = sweeping siren tone.
- Sits between the keypad/code-check logic (which supplies validated `arm`/`disarm` pulses) and the buzzer block.

Parameters:
- NZONES, 4, number of sensor zones.
- INSTANT_MASK, 4'b0001, zones that trigger ALARM immediately when ARMED. Other zones start ENTRY_DELAY.
- TICK_DIV, 25_000_000, clk cycles per tick (0.5 s at 50 MHz). The bench overrides this to 4.
- EXIT_TICKS, 60, length of the exit delay in ticks.
- ENTRY_TICKS, 30, length of the entry delay in ticks.
- ALARM_TICKS, 360, maximum siren duration in ticks before auto re-arm.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- arm  in  1  single-cycle pulse: request to arm.
- disarm  in  1  single-cycle pulse: valid code entered.
- zone  in  NZONES  sensor level, 1 = open/tripped. Already synchronized upstream.
- buzzer_aux  out  1  to buzzer `aux`.
- state  out  3  current state encoding (pkg constants).
- tripped  out  NZONES  latched zones that caused the last alarm.
- arm_fault  out  1  1-cycle pulse: arm rejected because a zone is open.
- armed_led  out  1  high in ARMED, ENTRY_DELAY and ALARM.

Behaviour:
- Reset (rst=1 at a clk edge) forces, on the next cycle:
  - state=DISARMED, buzzer_aux=0, tripped=0, arm_fault=0, armed_led=0.
  - Tick prescaler, tick counter, beep bit and bypass register all cleared.
  - Reset mid-alarm is honoured the same way.
- Tick generation:
  - Prescaler counts 0..TICK_DIV-1. `tick` is asserted for 1 cycle when it wraps.
  - Prescaler and tick counter clear on every state transition, so a delay of K ticks lasts exactly K*TICK_DIV cycles from the entry cycle.
- Beep bit: set to 1 on entry to EXIT_DELAY or ENTRY_DELAY, toggles on each tick.
- States and transitions (evaluated every cycle; disarm has highest priority):
  - DISARMED:
    - arm with zone==0 -> EXIT_DELAY.
    - arm with any zone=1 -> stay in DISARMED, arm_fault pulses 1 cycle.
    - buzzer_aux=0.
  - EXIT_DELAY:
    - disarm -> DISARMED.
    - EXIT_TICKS ticks elapsed -> ARMED; bypass is loaded with the zone value at that cycle.
    - Zones are ignored in this state.
    - buzzer_aux = beep bit.
  - ARMED:
    - disarm -> DISARMED.
    - Define active = zone & ~bypass.
    - active & INSTANT_MASK != 0 -> ALARM.
    - Otherwise active != 0 -> ENTRY_DELAY.
    - On either trip, tripped <= active.
    - Each bypass bit clears when its zone reads 0.
    - buzzer_aux=0.
  - ENTRY_DELAY:
    - disarm -> DISARMED.
    - Instant zone becomes active -> ALARM; tripped |= active.
    - ENTRY_TICKS ticks elapsed -> ALARM.
    - buzzer_aux = beep bit.
  - ALARM:
    - disarm -> DISARMED.
    - ALARM_TICKS ticks elapsed -> ARMED; bypass <= zone, so zones still open do not instantly retrigger.
    - buzzer_aux=1.
- Simultaneous events:
  - disarm and a trip in the same cycle -> DISARMED.
  - arm and disarm in the same cycle -> disarm wins, state stays or becomes DISARMED.
  - arm outside DISARMED is ignored (no fault).
- `tripped` holds its value through DISARMED for inspection. It clears only on rst or on the next transition from DISARMED into EXIT_DELAY.
- Output latency: all outputs are registered and reflect the new state one cycle after the causing input edge.
- Tick counter width: $clog2 of max(EXIT_TICKS, ENTRY_TICKS, ALARM_TICKS)+1. It saturates and never wraps.

Decomposition:
- Package alarm_pkg holds:
  - state encoding constants: DISARMED=0, EXIT_DELAY=1, ARMED=2, ENTRY_DELAY=3, ALARM=4 (3 bits).
  - default tick constants.
- Sub-module alarm_tick_gen (parameter TICK_DIV; inputs clk, rst, clr; output tick) provides the prescaler.
- The FSM, tick counter, bypass register and tripped latch stay in alarm_sequencer.

Test Plan (TICK_DIV=4, EXIT=3, ENTRY=2, ALARM=5, NZONES=4, INSTANT_MASK=4'b0001):
- Arm with zone=0 -> EXIT_DELAY next cycle, buzzer_aux toggles every 4 cycles starting at 1, state=ARMED exactly 12 cycles after entry.
- ARMED, zone=4'b0100 -> ENTRY_DELAY, tripped=4'b0100; no disarm -> ALARM after 8 cycles, buzzer_aux=1.
- ARMED, zone=4'b0001 -> ALARM next cycle, tripped=4'b0001, armed_led=1.
- ALARM with zone held 4'b0010 -> ARMED after 20 cycles and stays ARMED; zone drops to 0 then rises to 4'b0010 -> ENTRY_DELAY.
- arm while zone=4'b1000 -> arm_fault=1 for exactly 1 cycle, state stays DISARMED.
- ENTRY_DELAY with disarm and zone[0] rising in the same cycle -> DISARMED, buzzer_aux=0. rst asserted mid-ALARM -> all outputs 0 and state=0 next cycle.
